// File: rtl/clarke_pkg.sv
// Shared types and fixed-point gain constants for the Clarke transform pipeline.
package clarke_pkg;

    typedef enum logic {CLARKE_2IN, CLARKE_3IN} clarke_mode_e;

    // Rounded 1/sqrt(3) * 2^q; callers narrow the result to q+2 signed bits.
    function automatic logic signed [31:0] k_inv_sqrt3(input int q);
        real r;
        r = 0.57735026919 * (2.0 ** q);
        return 32'($rtoi(r + 0.5));
    endfunction

    // Rounded 2^q / 3, computed in integers as floor(2^q/3 + 1/2).
    function automatic logic signed [31:0] k_third(input int q);
        return 32'(((2 ** (q + 1)) + 3) / 6);
    endfunction

endpackage

// File: rtl/clarke_round_sat.sv
// Round-half-up, arithmetic shift by Q_BITS, then clamp or wrap to OUT_W signed bits.
module clarke_round_sat #(
    parameter int IN_W     = 46,
    parameter int Q_BITS   = 10,
    parameter int OUT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clamp
);
    // One guard bit so adding the half LSB can never overflow.
    localparam int SW = IN_W + 1;
    localparam logic signed [SW-1:0] HALF = SW'(2 ** (Q_BITS - 1));
    localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [SW-1:0] biased;
    logic signed [SW-1:0] shifted;

    assign biased  = SW'(din) + HALF;
    assign shifted = biased >>> Q_BITS;

    always_comb begin
        dout  = shifted[OUT_W-1:0];
        clamp = 1'b0;
        if (SATURATE != 0) begin
            if (shifted > MAXV) begin
                dout  = MAXV[OUT_W-1:0];
                clamp = 1'b1;
            end else if (shifted < MINV) begin
                dout  = MINV[OUT_W-1:0];
                clamp = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clarke_pipe.sv
// Three-stage amplitude-invariant Clarke transform (abc -> alpha/beta) with a
// single global advance for valid/ready back-pressure.
module clarke_pipe
    import clarke_pkg::*;
#(
    parameter int D_WIDTH  = 32,
    parameter int Q_BITS   = 10,
    parameter int SATURATE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic signed [D_WIDTH-1:0] a,
    input  logic signed [D_WIDTH-1:0] b,
    input  logic signed [D_WIDTH-1:0] c,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [D_WIDTH-1:0] alpha,
    output logic signed [D_WIDTH-1:0] beta,
    output logic                      sat
);
    localparam int PS_W = D_WIDTH + 2;
    localparam int PR_W = D_WIDTH + Q_BITS + 4;
    localparam int K_W  = Q_BITS + 2;
    localparam logic signed [K_W-1:0] K_IS3 = K_W'(k_inv_sqrt3(Q_BITS));
    localparam logic signed [K_W-1:0] K_TH  = K_W'(k_third(Q_BITS));

    logic adv;
    logic vld_p0, vld_p1;

    clarke_mode_e             mode_p0, mode_p1;
    logic signed [PS_W-1:0]   a_x, b_x, c_x;
    logic signed [PS_W-1:0]   ps_alpha, ps_beta;
    logic signed [PS_W-1:0]   ps_alpha_p0, ps_beta_p0;
    logic signed [PR_W-1:0]   pr_alpha_p1, pr_beta_p1;
    logic signed [D_WIDTH-1:0] rs_alpha, rs_beta, alpha_nxt;
    logic                     cl_alpha, cl_beta, sat_nxt;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    assign a_x = PS_W'(a);
    assign b_x = PS_W'(b);
    assign c_x = PS_W'(c);

    always_comb begin
        ps_alpha = a_x;
        ps_beta  = a_x + (b_x <<< 1);
        if (clarke_mode_e'(mode) == CLARKE_3IN) begin
            ps_alpha = (a_x <<< 1) - b_x - c_x;
            ps_beta  = b_x - c_x;
        end
    end

    // S1: exact pre-sums; mode-0 alpha rides along unscaled
    always_ff @(posedge clk) begin
        if (adv) begin
            mode_p0     <= clarke_mode_e'(mode);
            ps_alpha_p0 <= ps_alpha;
            ps_beta_p0  <= ps_beta;
        end
    end

    // S2: exact products
    always_ff @(posedge clk) begin
        if (adv) begin
            mode_p1     <= mode_p0;
            pr_beta_p1  <= PR_W'(ps_beta_p0) * PR_W'(K_IS3);
            pr_alpha_p1 <= (mode_p0 == CLARKE_3IN) ? PR_W'(ps_alpha_p0) * PR_W'(K_TH)
                                                   : PR_W'(ps_alpha_p0);
        end
    end

    clarke_round_sat #(.IN_W(PR_W), .Q_BITS(Q_BITS), .OUT_W(D_WIDTH), .SATURATE(SATURATE))
        u_rs_alpha (.din(pr_alpha_p1), .dout(rs_alpha), .clamp(cl_alpha));

    clarke_round_sat #(.IN_W(PR_W), .Q_BITS(Q_BITS), .OUT_W(D_WIDTH), .SATURATE(SATURATE))
        u_rs_beta (.din(pr_beta_p1), .dout(rs_beta), .clamp(cl_beta));

    assign alpha_nxt = (mode_p1 == CLARKE_3IN) ? rs_alpha : pr_alpha_p1[D_WIDTH-1:0];
    assign sat_nxt   = cl_beta | ((mode_p1 == CLARKE_3IN) & cl_alpha);

    // S3: rounded/saturated outputs and all valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            alpha     <= '0;
            beta      <= '0;
            sat       <= 1'b0;
        end else if (adv) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            out_valid <= vld_p1;
            alpha     <= alpha_nxt;
            beta      <= rs_beta;
            sat       <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_clarke_pipe.sv
// Scoreboard bench for clarke_pipe at D_WIDTH=16, Q_BITS=10, SATURATE=1.
module tb_clarke_pipe;
    localparam int W = 16;

    typedef struct {
        longint alpha;
        longint beta;
        logic   sat;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                mode = 1'b0;
    logic signed [W-1:0] a = '0, b = '0, c = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic signed [W-1:0] alpha, beta;
    logic                sat;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pop   = 0;
    exp_t sbq[$];

    logic                prev_stall = 1'b0;
    logic signed [W-1:0] prev_alpha, prev_beta;
    logic                prev_sat;

    clarke_pipe #(.D_WIDTH(W), .Q_BITS(10), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
        .alpha(alpha), .beta(beta), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint rnd_q10(input longint x);
        return (x + 512) >>> 10;
    endfunction

    function automatic longint clampw(input longint x, output logic hit);
        hit = 1'b0;
        if (x > 32767) begin hit = 1'b1; return 32767; end
        if (x < -32768) begin hit = 1'b1; return -32768; end
        return x;
    endfunction

    function automatic exp_t golden(input logic m, input logic signed [W-1:0] av,
                                    input logic signed [W-1:0] bv, input logic signed [W-1:0] cv);
        exp_t   e;
        longint la, lb, lc, ra, rb;
        logic   ha, hb;
        la = av; lb = bv; lc = cv;
        ha = 1'b0;
        if (!m) begin
            e.alpha = la;
            rb = rnd_q10((la + 2 * lb) * 591);
        end else begin
            ra = rnd_q10((2 * la - lb - lc) * 341);
            e.alpha = clampw(ra, ha);
            rb = rnd_q10((lb - lc) * 591);
        end
        e.beta = clampw(rb, hb);
        e.sat  = ha | hb;
        return e;
    endfunction

    function automatic logic signed [W-1:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'sh7FFF;
            1:       return 16'sh8000;
            default: return W'($urandom);
        endcase
    endfunction

    // Scoreboard, acceptance tracking and stall-stability checks, mid low phase.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                chk("stall_alpha", alpha, prev_alpha);
                chk("stall_beta", beta, prev_beta);
                chk("stall_sat", sat, prev_sat);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    n_pop++;
                    chk("sb_alpha", alpha, e.alpha);
                    chk("sb_beta", beta, e.beta);
                    chk("sb_sat", sat, e.sat);
                end
            end
            if (in_valid && in_ready)
                sbq.push_back(golden(mode, a, b, c));
            prev_stall = out_valid && !out_ready;
            prev_alpha = alpha;
            prev_beta  = beta;
            prev_sat   = sat;
        end
    end

    task automatic send1(input string tag, input logic m, input int av, input int bv, input int cv,
                         input int ea, input int eb, input int es);
        int lat;
        @(negedge clk);
        mode = m; a = W'(av); b = W'(bv); c = W'(cv); in_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            #3;
        end while (!out_valid && lat < 10);
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_alpha"}, alpha, ea);
        chk({tag, "_beta"}, beta, eb);
        chk({tag, "_sat"}, sat, es);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((sbq.size() != 0 || out_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sent, guard, held, pops0;
        logic need_new;

        // Reset state
        #13;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alpha", alpha, 0);
        chk("rst_beta", beta, 0);
        @(negedge clk); #1 rst = 1'b0;

        // Directed values
        send1("t1", 1'b0, 1024, 0, 0, 1024, 591, 0);
        send1("t2n", 1'b0, -1024, 0, 0, -1024, -591, 0);
        send1("t2s", 1'b0, 0, 32767, 0, 0, 32767, 1);
        send1("t3a", 1'b1, 1000, -500, -500, 999, 0, 0);
        send1("t3b", 1'b1, 0, 1024, -1024, 0, 1182, 0);
        send1("t3s", 1'b1, 32767, -32768, -32768, 32767, 0, 1);
        drain();

        // Random back-to-back with random back-pressure
        sent = 0; guard = 0; need_new = 1'b1;
        pops0 = n_pop;
        while (sent < 50 && guard < 2000) begin
            @(negedge clk);
            guard++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (need_new) begin
                mode = 1'($urandom_range(0, 1));
                a = rnd16(); b = rnd16(); c = rnd16();
                in_valid = 1'b1;
                need_new = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                sent++;
                need_new = 1'b1;
            end
        end
        chk("t4_sent", sent, 50);
        drain();
        chk("t4_pops", n_pop - pops0, 50);

        // Stall with input pressure: exactly three samples held
        held = 0; pops0 = n_pop;
        need_new = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            if (need_new) begin
                mode = 1'b1; a = W'(100 * (i + 1)); b = W'(-7 * i); c = W'(13 * i);
                need_new = 1'b0;
            end
            in_valid = 1'b1;
            #1;
            if (out_valid) chk("t6_in_ready", in_ready, 0);
            if (in_valid && in_ready) begin
                held++;
                need_new = 1'b1;
            end
        end
        chk("t6_held", held, 3);
        drain();
        chk("t6_pops", n_pop - pops0, 3);

        // Asynchronous reset with three samples in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mode = 1'b0; a = W'(500 + i); b = W'(200); c = '0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_alpha", alpha, 0);
        chk("t5_beta", beta, 0);
        chk("t5_in_ready", in_ready, 1);
        sbq.delete();
        @(negedge clk); #1 rst = 1'b0;
        send1("t5post", 1'b0, 1024, 0, 0, 1024, 591, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clarke_pipe.md
Name: clarke_pipe

Overview:
- Pipelined, parametrised Clarke (abc -> alpha/beta) transform with valid/ready streaming handshake.
- Adds a runtime-selectable three-input mode, round-half-up rescaling, saturation with a flag, and back-pressure.
- Sits between the phase-current ADC scaling stage and the Park transform in the FOC datapath.
- Amplitude-invariant in both modes.

Parameters:
- D_WIDTH, 32: signed width of every phase input and alpha/beta output.
- Q_BITS, 10: fractional bits of the fixed-point gain constants.
- SATURATE, 1: 1 = clamp outputs to the D_WIDTH signed range; 0 = truncate (wrap) to D_WIDTH bits.

Ports:
- clk  in  1  Clock.
- rst  in  1  Reset, asynchronous, active-high.
- in_valid  in  1  Input sample valid.
- in_ready  out  1  Block accepts a sample this cycle.
- mode  in  1  0 = two-input (c implied = -a-b); 1 = three-input (a, b, c used). Sampled with the data.
- a  in  D_WIDTH  Phase a, signed.
- b  in  D_WIDTH  Phase b, signed.
- c  in  D_WIDTH  Phase c, signed; ignored when mode=0.
- out_valid  out  1  alpha/beta valid.
- out_ready  in  1  Downstream accepts this cycle.
- alpha  out  D_WIDTH  Alpha component, signed.
- beta  out  D_WIDTH  Beta component, signed.
- sat  out  1  Alpha or beta was clamped for this sample; 0 when SATURATE=0.

Behaviour:
Constants, each rounded to nearest:
- K_INV_SQRT3 = round(0.57735026919 * 2^Q_BITS), 591 at Q=10.
- K_THIRD = round(2^Q_BITS / 3), 341 at Q=10.

Math:
- mode 0: alpha = a (no multiply, no rounding); beta = (a + 2b) * K_INV_SQRT3.
- mode 1: alpha = (2a - b - c) * K_THIRD; beta = (b - c) * K_INV_SQRT3.

Pipeline, 3 stages, latency exactly 3 cycles from accept to out_valid when never stalled:
- S1 registers pre-sums, D_WIDTH+2 bits signed, exact, no overflow possible.
- S2 registers products, D_WIDTH+Q_BITS+4 bits signed, exact.
- S3 rounds, shifts, saturates and registers the outputs.

Rounding:
- Add 2^(Q_BITS-1), then arithmetic shift right by Q_BITS (round half toward +inf).
- The mode-0 alpha passthrough is carried unscaled and bypasses rounding.

Saturation:
- Results above 2^(D_WIDTH-1)-1 clamp to max; results below -2^(D_WIDTH-1) clamp to min.
- sat = OR of the alpha and beta clamp events for that sample.

Handshake:
- Single global advance: adv = out_ready | ~out_valid; in_ready = adv.
- A sample is accepted on in_valid & in_ready.
- When adv=0, all stages and their valid bits hold. alpha/beta/sat stay stable while out_valid & ~out_ready.
- Bubbles are not compressed: a stalled pipe holds empty stages too.
- Throughput is 1 sample/cycle with out_ready held high.

Reset:
- Asynchronous assert clears every stage valid bit, alpha, beta and sat to 0.
- out_valid = 0 and in_ready = 1 during and after reset.
- Reset mid-operation discards all in-flight samples; no partial output is emitted.
- Data registers other than the outputs need no reset.

Other rules:
- mode travels with its sample, so mode changes between back-to-back samples are legal.

Decomposition:
- clarke_pkg holds:
  - typedef enum logic {CLARKE_2IN, CLARKE_3IN} clarke_mode_e;
  - constant functions k_inv_sqrt3(q) and k_third(q), which return the rounded constants as signed Q_BITS+2-bit values.
- Sub-module clarke_round_sat (params IN_W, Q_BITS, OUT_W, SATURATE): purely combinational round/shift/clamp returning value and clamp flag. Instantiated twice in S3.

Test Plan:
All scenarios use D_WIDTH=16, Q_BITS=10, SATURATE=1.
1. mode 0, a=1024, b=0, single beat, out_ready=1 -> 3 cycles later alpha=1024, beta=591, sat=0.
2. mode 0, a=-1024, b=0 -> alpha=-1024, beta=-591 (checks negative rounding). Then a=0, b=32767 -> beta=32767, sat=1.
3. mode 1, a=1000, b=-500, c=-500 -> alpha=999, beta=0. Then a=0, b=1024, c=-1024 -> alpha=0, beta=1182.
4. 50 random back-to-back samples with mixed modes and out_ready randomly toggled -> outputs match a golden model in order with no loss or duplication. alpha/beta stay stable during every stall.
5. Three samples in flight, rst pulsed asynchronously mid-cycle -> out_valid=0, alpha=beta=0 immediately. The first post-reset sample emerges after exactly 3 cycles with the correct value.
6. out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0 once out_valid=1. Exactly 3 samples held, then released in order when out_ready rises.
